seq_shifter: RTL and testbench

Multi-cycle, parametrised shift/rotate unit for the datapath ALU. It replaces single-cycle 16-bit shifting with an iterative engine of configurable width and per-cycle step size. It adds start/done handshaking, rotate modes, and registered carry-out and zero flags. The control unit stalls on `busy` and consumes the result when `done` pulses.

---
 rtl/seq_shifter.sv | 169 ++++++++++++++++
 tb/tb_seq_shifter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// seq_shifter -- iterative shift/rotate engine for the datapath ALU.
//
// Shifts an operand by 0..WIDTH-1 positions, at most STEP positions per
// cycle, and reports completion with a one-cycle done pulse.
//
// Parameters:
//   WIDTH  data width (power of two, >= 4)
//   SHW    shift-amount width, derived from WIDTH; do not override
//   STEP   max bit positions moved per cycle (power of two, 1..WIDTH)
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high
//   start    request; only accepted in IDLE or DONE
//   op       000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR; others illegal
//   data_in  operand, captured on an accepted start
//   amount   shift count, captured on an accepted start
//   busy     high while shifting
//   done     one-cycle pulse, result valid
//   err      pulses with done for an illegal op
//   result   registered result, held until the next completion
//   carry    last bit moved out (0 for amount 0)
//   zero     result == 0, registered with result
//
// Build option: define SEQ_SHIFTER_ROTATE_EN to build ROL/ROR. Without it
// opcodes 011/100 are reported as illegal.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH),
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   amount,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // One extra bit so STEP == WIDTH and WIDTH itself are representable.
  localparam logic [SHW:0] STEP_K  = (SHW+1)'(STEP);
  localparam logic [SHW:0] WIDTH_K = (SHW+1)'(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   rem;
  logic [2:0]       op_q;
  logic             err_q;

  logic [SHW:0]     k;
  logic [SHW-1:0]   rem_nxt;
  logic [WIDTH-1:0] work_nxt;
  logic [WIDTH-1:0] left_out;
  logic [WIDTH-1:0] right_out;
  logic             carry_nxt;

  function automatic logic op_legal(input logic [2:0] o);
`ifdef SEQ_SHIFTER_ROTATE_EN
    return (o <= OP_ROR);
`else
    return (o <= OP_SRA);
`endif
  endfunction

  // One shift step. k is never larger than rem, so rem cannot underflow
  // and k < WIDTH always holds while shifting.
  always_comb begin
    k         = ({1'b0, rem} > STEP_K) ? STEP_K : {1'b0, rem};
    rem_nxt   = rem - k[SHW-1:0];
    // Bit 0 of these is the last bit leaving the left / right end.
    left_out  = work >> (WIDTH_K - k);
    right_out = work >> (k - 1'b1);
    work_nxt  = work;
    carry_nxt = 1'b0;
    case (op_q)
      OP_SLL: begin
        work_nxt  = work << k;
        carry_nxt = left_out[0];
      end
      OP_SRL: begin
        work_nxt  = work >> k;
        carry_nxt = right_out[0];
      end
      OP_SRA: begin
        work_nxt  = $signed(work) >>> k;
        carry_nxt = right_out[0];
      end
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROL: begin
        work_nxt  = (work << k) | (work >> (WIDTH_K - k));
        carry_nxt = left_out[0];
      end
      OP_ROR: begin
        work_nxt  = (work >> k) | (work << (WIDTH_K - k));
        carry_nxt = right_out[0];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      work   <= '0;
      rem    <= '0;
      op_q   <= OP_SLL;
      err_q  <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      zero   <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_q <= op;
            work <= data_in;
            rem  <= amount;
            if (amount != '0 && op_legal(op)) begin
              state <= SHIFT;
              err_q <= 1'b0;
            end else begin
              // Nothing to shift (or illegal): complete with the operand.
              state  <= DONE;
              err_q  <= !op_legal(op);
              result <= data_in;
              carry  <= 1'b0;
              zero   <= (data_in == '0);
            end
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          work <= work_nxt;
          rem  <= rem_nxt;
          if (rem_nxt == '0) begin
            state  <= DONE;
            result <= work_nxt;
            carry  <= carry_nxt;
            zero   <= (work_nxt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);
  assign err  = done & err_q;

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter -- scoreboard bench for seq_shifter (default parameters).
// Stimulus pushes expected completions (with their cycle) and expected
// status snapshots; a negedge monitor pops and compares them.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [15:0] data_in;
  logic [3:0]  amount;
  logic        busy, done, err, carry, zero;
  logic [15:0] result;

  seq_shifter dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .data_in(data_in),
    .amount(amount), .busy(busy), .done(done), .err(err), .result(result),
    .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        e;
  } exp_t;

  typedef struct {
    int          cyc;
    logic        busy;
    logic        done;
    logic        full;
    logic        e;
    logic        c;
    logic        z;
    logic [15:0] res;
  } st_t;

  exp_t sb[$];
  st_t  stq[$];
  exp_t me;
  st_t  ms;

  int   cyc = 0;
  int   t0;
  int   total = 0;
  int   bad = 0;
  logic end_chk = 1'b0;
  logic end_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: completion scoreboard, status snapshots, final drain check.
  always @(negedge clk) begin
    if (!reset && done) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done cyc=%0d got result=%h, required no done", cyc, result);
      end else begin
        me = sb.pop_front();
        if (cyc != me.cyc || result !== me.res || carry !== me.c ||
            zero !== me.z || err !== me.e) begin
          bad++;
          $display("FAIL done_chk cyc=%0d got r=%h c=%b z=%b e=%b, required cyc=%0d r=%h c=%b z=%b e=%b",
                   cyc, result, carry, zero, err, me.cyc, me.res, me.c, me.z, me.e);
        end
      end
    end
    if (stq.size() > 0 && stq[0].cyc <= cyc) begin
      ms = stq.pop_front();
      total++;
      if (ms.cyc != cyc || busy !== ms.busy || done !== ms.done ||
          (ms.full && (err !== ms.e || carry !== ms.c || zero !== ms.z ||
                       result !== ms.res))) begin
        bad++;
        $display("FAIL status_chk cyc=%0d got busy=%b done=%b e=%b c=%b z=%b r=%h, required cyc=%0d busy=%b done=%b e=%b c=%b z=%b r=%h",
                 cyc, busy, done, err, carry, zero, result,
                 ms.cyc, ms.busy, ms.done, ms.e, ms.c, ms.z, ms.res);
      end
    end
    if (end_chk && !end_seen) begin
      end_seen = 1'b1;
      total++;
      if (sb.size() != 0 || stq.size() != 0) begin
        bad++;
        $display("FAIL drain got pending_done=%0d pending_status=%0d, required 0 and 0",
                 sb.size(), stq.size());
      end
    end
  end

  // One-cycle start pulse; returns in cycle t0+1 (t0 = cycle start was high).
  task automatic issue(input logic [2:0] o, input logic [15:0] d, input logic [3:0] a,
                       input int s, input logic [15:0] er, input logic ec,
                       input logic ez, input logic ee, input bit push);
    @(posedge clk); #1;
    start = 1'b1; op = o; data_in = d; amount = a;
    t0 = cyc;
    if (push) sb.push_back('{cyc + s + 1, er, ec, ez, ee});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic stat(input int c, input logic b, input logic dn, input logic f,
                      input logic e, input logic cy, input logic z, input logic [15:0] r);
    stq.push_back('{c, b, dn, f, e, cy, z, r});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd0; data_in = '0; amount = '0;
    idle(3); #1;
    reset = 1'b0;
    stat(cyc, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);

    // SLL 0x0001 by 4: one shift cycle.
    issue(3'b000, 16'h0001, 4'd4, 1, 16'h0010, 1'b0, 1'b0, 1'b0, 1);
    stat(t0 + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    idle(3);

    // SRA 0xC000 by 15: worst-case latency.
    issue(3'b010, 16'hC000, 4'd15, 4, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1);
    for (int i = 1; i <= 4; i++) stat(t0 + i, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    stat(t0 + 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    idle(6);

    // SRL 0x0001 by 1, then back-to-back SRL 0x00F0 by 0 from the DONE cycle.
    issue(3'b001, 16'h0001, 4'd1, 1, 16'h0000, 1'b1, 1'b1, 1'b0, 1);
    issue(3'b001, 16'h00F0, 4'd0, 0, 16'h00F0, 1'b0, 1'b0, 1'b0, 1);
    idle(3);

    // ROL / ROR: implemented only with the rotate build option.
`ifdef SEQ_SHIFTER_ROTATE_EN
    issue(3'b011, 16'h8001, 4'd1, 1, 16'h0003, 1'b1, 1'b0, 1'b0, 1);
    idle(3);
    issue(3'b100, 16'h0001, 4'd4, 1, 16'h1000, 1'b0, 1'b0, 1'b0, 1);
`else
    issue(3'b011, 16'h8001, 4'd1, 0, 16'h8001, 1'b0, 1'b0, 1'b1, 1);
    idle(3);
    issue(3'b100, 16'h0001, 4'd4, 0, 16'h0001, 1'b0, 1'b0, 1'b1, 1);
`endif
    idle(3);

    // Reset mid-operation: abort, reset values, no done afterwards.
    issue(3'b000, 16'h00FF, 4'd12, 3, 16'h0, 1'b0, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    stat(t0 + 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    idle(6);

    // Illegal op completes immediately with the operand.
    issue(3'b111, 16'h1234, 4'd5, 0, 16'h1234, 1'b0, 1'b0, 1'b1, 1);
    idle(3);

    // Start during SHIFT is ignored; result then holds.
    issue(3'b001, 16'hFFFF, 4'd8, 2, 16'h00FF, 1'b1, 1'b0, 1'b0, 1);
    start = 1'b1; op = 3'b000; data_in = 16'h0000; amount = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    stat(t0 + 4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00FF);
    idle(4);

    // SLL 0x0003 by 15 (last step is 3 positions).
    issue(3'b000, 16'h0003, 4'd15, 4, 16'h8000, 1'b1, 1'b0, 1'b0, 1);
    idle(6);

    // SRA of positive value by 4.
    issue(3'b010, 16'h7FF0, 4'd4, 1, 16'h07FF, 1'b0, 1'b0, 1'b0, 1);
    idle(3);

    // SRA by 0: passes operand, carry 0.
    issue(3'b010, 16'h8000, 4'd0, 0, 16'h8000, 1'b0, 1'b0, 1'b0, 1);
    idle(10);

    end_chk = 1'b1;
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
